// File: rtl/reg_pkg.sv
// Shared op-select encoding for the accumulator/address register and the
// core control FSM that drives it, plus the priority encoder that maps the
// individual strobe inputs onto a single operation.
package reg_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_CLR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_ACC  = 3'd3,
    OP_INCK = 3'd4,
    OP_INC  = 3'd5
  } op_e;

  // Exactly one accumulator op per cycle: clr > load > acc > inck > inc.
  function automatic op_e op_select(input logic clr, input logic load,
                                    input logic acc, input logic inck,
                                    input logic inc);
    op_e op;
    op = OP_HOLD;
    if (clr)       op = OP_CLR;
    else if (load) op = OP_LOAD;
    else if (acc)  op = OP_ACC;
    else if (inck) op = OP_INCK;
    else if (inc)  op = OP_INC;
    return op;
  endfunction

endpackage

// File: rtl/reg_ac_addsat.sv
// WIDTH+1 bit adder with a build-time choice of wrap or clamp-to-all-ones.
// The carry out is reported in both modes so the caller can track overflow.
module reg_ac_addsat #(
  parameter int WIDTH = 16,
  parameter int SAT   = 0
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH:0] wide_sum;

  assign wide_sum = {1'b0, a_i} + {1'b0, b_i};
  assign carry_o  = wide_sum[WIDTH];

  generate
    if (SAT != 0) begin : g_sat
      // Clamp: any carry out pins the result at the largest representable value.
      always_comb begin
        sum_o = wide_sum[WIDTH-1:0];
        if (wide_sum[WIDTH]) sum_o = '1;
      end
    end else begin : g_wrap
      // Wrap: drop the carry, result is modulo 2^WIDTH.
      always_comb begin
        sum_o = wide_sum[WIDTH-1:0];
      end
    end
  endgenerate

endmodule

// File: rtl/reg_ac_multi.sv
// Accumulator/address register for the matrix-multiply cores: load, +1,
// +stride K, +data_in accumulate and clear, with wrap/saturate arithmetic,
// sticky overflow and limit detection for loop control.
module reg_ac_multi
  import reg_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SAT     = 0,
  parameter int K_RESET = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load_enable,
  input  logic             acc,
  input  logic             inck,
  input  logic             inc,
  input  logic             load_k,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] k_out,
  output logic             ovf,
  output logic             zero,
  output logic             at_limit,
  output logic             hit
);

  op_e              op;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             carry;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             ovf_q, ovf_d;
  logic             hit_q, hit_d;

  // Decode the strobes into one op and pick the adder operand for it.
  always_comb begin
    op     = op_select(clr, load_enable, acc, inck, inc);
    addend = WIDTH'(1);
    case (op)
      OP_ACC:  addend = data_in;
      OP_INCK: addend = k_q;     // old K even when load_k is high this cycle
      default: addend = WIDTH'(1);
    endcase
  end

  reg_ac_addsat #(
    .WIDTH (WIDTH),
    .SAT   (SAT)
  ) u_addsat (
    .a_i     (acc_q),
    .b_i     (addend),
    .sum_o   (sum),
    .carry_o (carry)
  );

  // Next-state for accumulator, sticky overflow, hit pulse and stride.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    hit_d = 1'b0;
    k_d   = load_k ? data_in : k_q;
    case (op)
      OP_CLR: begin
        acc_d = '0;
        ovf_d = 1'b0;
      end
      OP_LOAD: begin
        acc_d = data_in;
        ovf_d = 1'b0;
      end
      OP_ACC, OP_INCK, OP_INC: begin
        acc_d = sum;
        ovf_d = ovf_q | carry;
        hit_d = (sum == limit);
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  // State registers; reset takes effect immediately and discards any op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      k_q   <= WIDTH'(K_RESET);
      ovf_q <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      k_q   <= k_d;
      ovf_q <= ovf_d;
      hit_q <= hit_d;
    end
  end

  assign data_out = acc_q;
  assign k_out    = k_q;
  assign ovf      = ovf_q;
  assign hit      = hit_q;
  assign zero     = (acc_q == '0);
  assign at_limit = (acc_q == limit);

endmodule

// File: tb/tb_reg_ac_multi.sv
// Scoreboard bench for reg_ac_multi: a wrapping and a saturating instance
// share stimulus; each directed vector names the instance it targets.
module tb_reg_ac_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr, load_enable, acc, inck, inc, load_k;
  logic [15:0] data_in, limit;

  logic [15:0] w_data, w_k, s_data, s_k;
  logic        w_ovf, w_zero, w_atl, w_hit;
  logic        s_ovf, s_zero, s_atl, s_hit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_ac_multi #(.WIDTH(16), .SAT(0), .K_RESET(1)) u_wrap (
    .clk(clk), .reset(reset), .clr(clr), .load_enable(load_enable),
    .acc(acc), .inck(inck), .inc(inc), .load_k(load_k),
    .data_in(data_in), .limit(limit),
    .data_out(w_data), .k_out(w_k), .ovf(w_ovf), .zero(w_zero),
    .at_limit(w_atl), .hit(w_hit)
  );

  reg_ac_multi #(.WIDTH(16), .SAT(1), .K_RESET(1)) u_sat (
    .clk(clk), .reset(reset), .clr(clr), .load_enable(load_enable),
    .acc(acc), .inck(inck), .inc(inc), .load_k(load_k),
    .data_in(data_in), .limit(limit),
    .data_out(s_data), .k_out(s_k), .ovf(s_ovf), .zero(s_zero),
    .at_limit(s_atl), .hit(s_hit)
  );

  // Strobe bit positions: {clr, load_enable, acc, inck, inc, load_k}
  localparam logic [5:0] C  = 6'b100000;
  localparam logic [5:0] L  = 6'b010000;
  localparam logic [5:0] A  = 6'b001000;
  localparam logic [5:0] KI = 6'b000100;
  localparam logic [5:0] I  = 6'b000010;
  localparam logic [5:0] LK = 6'b000001;
  localparam logic [5:0] H  = 6'b000000;
  localparam bit W = 1'b0;
  localparam bit S = 1'b1;

  typedef struct {
    bit          sel;
    logic [15:0] data;
    logic [15:0] k;
    logic        ovf;
    logic        hit;
    logic        zero;
    logic        atl;
    string       nm;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    {clr, load_enable, acc, inck, inc, load_k} = 6'b0;
    data_in = 16'h0;
  endtask

  // Drive one cycle of stimulus and queue the state expected after the edge.
  task automatic op(input logic [5:0] ops, input logic [15:0] din,
                    input logic [15:0] lim, input bit sel,
                    input logic [15:0] e_data, input logic [15:0] e_k,
                    input logic e_ovf, input logic e_hit, input string nm);
    exp_t e;
    @(negedge clk);
    {clr, load_enable, acc, inck, inc, load_k} = ops;
    data_in = din;
    limit   = lim;
    e.sel  = sel;
    e.data = e_data;
    e.k    = e_k;
    e.ovf  = e_ovf;
    e.hit  = e_hit;
    e.zero = (e_data == 16'h0);
    e.atl  = (e_data == lim);
    e.nm   = nm;
    sb.push_back(e);
  endtask

  // Monitor: one expectation per rising edge, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    logic [15:0] a_data, a_k;
    logic        a_ovf, a_hit, a_zero, a_atl;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel) begin
        a_data = s_data; a_k = s_k; a_ovf = s_ovf;
        a_hit = s_hit; a_zero = s_zero; a_atl = s_atl;
      end else begin
        a_data = w_data; a_k = w_k; a_ovf = w_ovf;
        a_hit = w_hit; a_zero = w_zero; a_atl = w_atl;
      end
      $display("txn %-14s sat=%0d data=%h k=%h ovf=%b hit=%b zero=%b at_limit=%b",
               e.nm, e.sel, a_data, a_k, a_ovf, a_hit, a_zero, a_atl);
      chk({e.nm, ".data"},     a_data,        e.data);
      chk({e.nm, ".k"},        a_k,           e.k);
      chk({e.nm, ".ovf"},      16'(a_ovf),    16'(e.ovf));
      chk({e.nm, ".hit"},      16'(a_hit),    16'(e.hit));
      chk({e.nm, ".zero"},     16'(a_zero),   16'(e.zero));
      chk({e.nm, ".at_limit"}, 16'(a_atl),    16'(e.atl));
    end
  end

  task automatic chk_reset_state(input string nm);
    chk({nm, ".w_data"}, w_data, 16'h0);
    chk({nm, ".w_k"},    w_k,    16'h1);
    chk({nm, ".w_ovf"},  16'(w_ovf), 16'h0);
    chk({nm, ".w_hit"},  16'(w_hit), 16'h0);
    chk({nm, ".s_data"}, s_data, 16'h0);
    chk({nm, ".s_k"},    s_k,    16'h1);
    chk({nm, ".s_ovf"},  16'(s_ovf), 16'h0);
    chk({nm, ".s_hit"},  16'(s_hit), 16'h0);
  endtask

  initial begin
    int budget;
    reset = 1'b1;
    limit = 16'h00FF;
    clear_inputs();
    repeat (2) @(negedge clk);
    chk_reset_state("reset_init");
    reset = 1'b0;

    // Async reset mid-stream with data_out=0x1234, hit=1 and K=7.
    op(L,     16'h1233, 16'h1234, W, 16'h1233, 16'h0001, 0, 0, "pre_ld");
    op(I|LK,  16'h0007, 16'h1234, W, 16'h1234, 16'h0007, 0, 1, "pre_inc_hit");
    @(posedge clk);
    #3 reset = 1'b1;
    #1 chk_reset_state("reset_async");
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;

    // Load, +1, stride load concurrent with inck (old K), then new K.
    op(L,     16'h0002, 16'h00FF, W, 16'h0002, 16'h0001, 0, 0, "ld2");
    op(I,     16'h0000, 16'h00FF, W, 16'h0003, 16'h0001, 0, 0, "inc3");
    op(KI|LK, 16'h0005, 16'h00FF, W, 16'h0004, 16'h0005, 0, 0, "inck_oldk");
    op(KI,    16'h0000, 16'h00FF, W, 16'h0009, 16'h0005, 0, 0, "inck_newk");

    // Wrap-around carry, sticky ovf, load clears it.
    op(L,     16'hFFFE, 16'h00FF, W, 16'hFFFE, 16'h0005, 0, 0, "ld_fffe");
    op(I,     16'h0000, 16'h00FF, W, 16'hFFFF, 16'h0005, 0, 0, "inc_ffff");
    op(I,     16'h0000, 16'h00FF, W, 16'h0000, 16'h0005, 1, 0, "inc_wrap");
    op(H,     16'h0000, 16'h00FF, W, 16'h0000, 16'h0005, 1, 0, "hold_ovf");
    op(L,     16'h0007, 16'h00FF, W, 16'h0007, 16'h0005, 0, 0, "ld7_clrovf");
    op(L,     16'h8000, 16'h00FF, W, 16'h8000, 16'h0005, 0, 0, "ld_8000");
    op(A,     16'h8001, 16'h00FF, W, 16'h0001, 16'h0005, 1, 0, "acc_wrap");

    // Priority among simultaneous strobes.
    op(L|A,      16'h0009, 16'h00FF, W, 16'h0009, 16'h0005, 0, 0, "prio_ld_acc");
    op(A|KI|I,   16'h0003, 16'h00FF, W, 16'h000C, 16'h0005, 0, 0, "prio_acc");
    op(KI|I,     16'h0000, 16'h00FF, W, 16'h0011, 16'h0005, 0, 0, "prio_inck");

    // Saturating instance: clamp at all-ones, hit on a clamped result.
    op(L,     16'hFFF0, 16'hFFFF, S, 16'hFFF0, 16'h0005, 0, 0, "s_ld_fff0");
    op(A,     16'h0020, 16'hFFFF, S, 16'hFFFF, 16'h0005, 1, 1, "s_acc_sat");
    op(I,     16'h0000, 16'h00FF, S, 16'hFFFF, 16'h0005, 1, 0, "s_inc_hold");
    op(KI,    16'h0000, 16'h00FF, S, 16'hFFFF, 16'h0005, 1, 0, "s_inck_hold");
    op(L,     16'hFFFF, 16'h00FF, S, 16'hFFFF, 16'h0005, 0, 0, "s_ld_ffff");
    op(A,     16'h0000, 16'h00FF, S, 16'hFFFF, 16'h0005, 0, 0, "s_acc_zero");

    // Limit detection and the one-cycle hit pulse.
    op(L|LK,  16'h0002, 16'h0006, W, 16'h0002, 16'h0002, 0, 0, "lim_ld2");
    op(KI,    16'h0000, 16'h0006, W, 16'h0004, 16'h0002, 0, 0, "lim_inck4");
    op(KI,    16'h0000, 16'h0006, W, 16'h0006, 16'h0002, 0, 1, "lim_inck6");
    op(H,     16'h0000, 16'h0006, W, 16'h0006, 16'h0002, 0, 0, "lim_hold");
    op(L,     16'h0006, 16'h0006, W, 16'h0006, 16'h0002, 0, 0, "lim_ld6");
    op(LK,    16'h0000, 16'h0006, W, 16'h0006, 16'h0000, 0, 0, "lim_k0");
    op(KI,    16'h0000, 16'h0006, W, 16'h0006, 16'h0000, 0, 1, "lim_add0_hit");

    // Clear wins over every other strobe and drops sticky ovf.
    op(L,     16'hFFFF, 16'h00FF, W, 16'hFFFF, 16'h0000, 0, 0, "c_ld_ffff");
    op(I,     16'h0000, 16'h00FF, W, 16'h0000, 16'h0000, 1, 0, "c_inc_wrap");
    op(I,     16'h0000, 16'h00FF, W, 16'h0001, 16'h0000, 1, 0, "c_inc1");
    op(C|L|A|KI|I, 16'h0005, 16'h00FF, W, 16'h0000, 16'h0000, 0, 0, "c_all_high");

    @(negedge clk);
    clear_inputs();
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
